crc32_multibyte_engine: RTL
===========================

// Module: crc32_multibyte_engine
// PURPOSE
//  - Frame-based CRC-32 (IEEE 802.3 / GZIP) engine taking DATA_BYTES bytes per beat with byte enables.
//  - Sits at the GZIP output stage: computes the member CRC32 and ISIZE (byte count mod 2^32).
//  - Replaces the 1-byte CRC32 block. Explicit sof/eof framing removes the need to reset between frames.
// PARAMETERS
//  DATA_BYTES  4             bytes per input beat; legal values 1, 2, 4, 8
//  POLY_REFL   32'hEDB88320  reflected generator polynomial
//  CRC_INIT    32'hFFFFFFFF  register value loaded at sof
//  CRC_XOROUT  32'hFFFFFFFF  value XORed into the register to form crc_out
// PORTS
//  clk            in   1               clock; all logic on its rising edge
//  rst            in   1               reset; synchronous, active-high
//  data_in        in   8*DATA_BYTES    payload; byte 0 = [7:0], processed first
//  data_be_in     in   DATA_BYTES      byte enables; must be contiguous from bit 0
//  data_valid_in  in   1               beat valid
//  sof_in         in   1               first beat of frame (qualified by valid)
//  eof_in         in   1               last beat of frame (qualified by valid)
//  ready_out      out  1               engine accepts a beat when valid && ready
//  crc_out        out  32              final CRC (already XORed with CRC_XOROUT)
//  isize_out      out  32              frame byte count mod 2^32
//  crc_valid_out  out  1               one-cycle pulse: crc_out/isize_out are final
//  err_out        out  1               one-cycle pulse: protocol error
// BEHAVIOUR
//  - Reset values: ready_out=1, crc_out=0, isize_out=0, crc_valid_out=0, err_out=0, state=IDLE.
//  - FSM states: IDLE, ACCUM, DONE.
//  - Beat acceptance: a beat is taken when data_valid_in && ready_out.
//  - IDLE, accepted beat with sof_in:
//      crc_reg = CRC_INIT folded with the enabled bytes; byte counter = popcount(be).
//      Next state is ACCUM, or DONE if eof_in is also set (single-beat frame).
//  - IDLE, accepted beat without sof_in: beat dropped, err_out pulses, stays IDLE.
//  - ACCUM, accepted beat: fold the enabled bytes LSB-first; counter += popcount(be).
//      Counter wraps mod 2^32. eof_in moves to DONE.
//  - ACCUM, sof_in on a beat: previous frame abandoned (no crc_valid_out), err_out pulses.
//      The new frame restarts from CRC_INIT with this beat.
//  - DONE (exactly one cycle): ready_out=0; crc_out = crc_reg ^ CRC_XOROUT; isize_out = counter.
//      crc_valid_out=1; next state IDLE.
//  - Latency: crc_valid_out asserts on the cycle after the eof beat is accepted.
//  - crc_out/isize_out hold their last final values until the next DONE.
//  - data_be_in==0 on a beat: counts as a beat (sof/eof still act) but folds no bytes.
//  - Non-contiguous enables: undefined; a debug-only assertion flags them.
//  - rst mid-frame: next edge returns to reset values; the partial frame is discarded.
//  - Fold logic: combinational unrolled byte-wise update over DATA_BYTES, single cycle per beat.
// CONFIGURATION
//  - Macro CRC_TRAILER_SER_EN:
//    * Defined: adds ports trl_data_out[7:0] (out), trl_valid_out (out), trl_ready_in (in),
//      trl_last_out (out), and state TRAILER after DONE.
//    * TRAILER streams 8 bytes: crc_out LE, then isize_out LE, advancing on trl_valid_out && trl_ready_in.
//    * trl_last_out is high on byte 8.
//    * ready_out=0 while in TRAILER; returns to IDLE after byte 8 is taken.
//    * Trailer port reset values: trl_valid_out=0, trl_last_out=0, trl_data_out=0.
//    * Not defined: no trailer ports; DONE always returns to IDLE.
// TESTING
//  - DATA_BYTES=1, "0123456789" sof on '0', eof on '9' -> crc_out=A684C7C6, isize_out=10, one crc_valid_out pulse.
//  - DATA_BYTES=4, 8 beats of 32'h00000000 be=4'hF -> crc_out=190A55AD, isize_out=32.
//    Next frame: 8 beats of 32'hFFFFFFFF -> FF6CAB0B (no reset between frames).
//  - DATA_BYTES=4, bytes 00..1F -> 91267E8A.
//    "The quick brown fox jumps over the lazy dog": 11 beats, last be=4'b0111 -> 414FA339, isize_out=43.
//  - DATA_BYTES=4: sof after 3 beats of junk, then "0123456789" (last be=4'b0011) -> err_out pulse, A684C7C6.
//    Separately, rst asserted mid-frame -> all outputs return to reset values; no crc_valid_out.
//  - CRC_TRAILER_SER_EN, "0123456789", trl_ready_in toggling 1/0 -> trailer bytes C6 C7 84 A6 0A 00 00 00.
//    trl_last_out on the 8th byte; ready_out low throughout.

Source files
------------

// File: rtl/crc32_multibyte_engine.sv
// crc32_multibyte_engine
//   Frame-based CRC-32 (reflected, IEEE 802.3 / GZIP) over DATA_BYTES bytes per beat,
//   with byte enables and sof/eof framing. Produces the member CRC32 and ISIZE
//   (byte count mod 2^32) for the GZIP trailer.
//
//   Optional build macro CRC_TRAILER_SER_EN: adds a byte-serial trailer port that
//   streams crc_out (little-endian) followed by isize_out (little-endian) after
//   each completed frame.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for a beat carrying sof_in; other beats are errors
//   ACCUM   | inside a frame, folding enabled bytes into the running CRC
//   DONE    | one cycle: crc_out/isize_out final, crc_valid_out high
//   TRAILER | (macro builds only) streaming the 8 trailer bytes
module crc32_multibyte_engine #(
    parameter int          DATA_BYTES = 4,
    parameter logic [31:0] POLY_REFL  = 32'hEDB88320,
    parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] CRC_XOROUT = 32'hFFFFFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*DATA_BYTES-1:0] data_in,
    input  logic [DATA_BYTES-1:0]   data_be_in,
    input  logic                    data_valid_in,
    input  logic                    sof_in,
    input  logic                    eof_in,
    output logic                    ready_out,
    output logic [31:0]             crc_out,
    output logic [31:0]             isize_out,
    output logic                    crc_valid_out,
`ifdef CRC_TRAILER_SER_EN
    output logic                    err_out,
    output logic [7:0]              trl_data_out,
    output logic                    trl_valid_out,
    input  logic                    trl_ready_in,
    output logic                    trl_last_out
`else
    output logic                    err_out
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DONE    = 2'd2,
        TRAILER = 2'd3
    } state_t;

    localparam logic [DATA_BYTES-1:0] BE_ONE = DATA_BYTES'(1);

    state_t      state_q;
    logic        ready_q;
    logic [31:0] crc_q;
    logic [31:0] cnt_q;
    logic [31:0] crc_out_q;
    logic [31:0] isize_q;
    logic        crc_valid_q;
    logic        err_q;

    logic        beat_acc;
    logic [31:0] crc_base;
    logic [31:0] cnt_base;
    logic [31:0] crc_d;
    logic [31:0] cnt_d;

`ifdef CRC_TRAILER_SER_EN
    logic [7:0]  trl_data_q;
    logic        trl_valid_q;
    logic        trl_last_q;
    logic [2:0]  trl_idx_q;
    logic [2:0]  trl_idx_d;
    logic [63:0] trl_word;
`endif

    // Byte-serial reflected CRC update, unrolled over the enabled bytes (byte 0 first).
    function automatic logic [31:0] fold_beat(
        input logic [31:0]             crc_in,
        input logic [8*DATA_BYTES-1:0] d,
        input logic [DATA_BYTES-1:0]   be
    );
        logic [31:0] c;
        c = crc_in;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (be[b]) begin
                c = c ^ {24'h0, d[8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] popcount(input logic [DATA_BYTES-1:0] be);
        logic [31:0] n;
        n = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            n = n + {31'h0, be[b]};
        end
        return n;
    endfunction

    // Next CRC and byte count if the current beat is accepted; sof restarts both.
    always_comb begin
        beat_acc = data_valid_in && ready_q;
        crc_base = sof_in ? CRC_INIT : crc_q;
        cnt_base = sof_in ? 32'h0 : cnt_q;
        crc_d    = fold_beat(crc_base, data_in, data_be_in);
        cnt_d    = cnt_base + popcount(data_be_in);
    end

`ifdef CRC_TRAILER_SER_EN
    // Trailer byte order: CRC little-endian, then ISIZE little-endian.
    always_comb begin
        trl_word  = {isize_q, crc_out_q};
        trl_idx_d = trl_idx_q + 3'd1;
    end
`endif

    // Frame FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            crc_q       <= CRC_INIT;
            cnt_q       <= '0;
            crc_out_q   <= '0;
            isize_q     <= '0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef CRC_TRAILER_SER_EN
            trl_data_q  <= '0;
            trl_valid_q <= 1'b0;
            trl_last_q  <= 1'b0;
            trl_idx_q   <= '0;
`endif
        end else begin
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_acc) begin
                        if (state_q == IDLE && !sof_in) begin
                            // Beat outside a frame: dropped.
                            err_q <= 1'b1;
                        end else begin
                            // sof inside a frame abandons the old frame.
                            if (state_q == ACCUM && sof_in) begin
                                err_q <= 1'b1;
                            end
                            crc_q <= crc_d;
                            cnt_q <= cnt_d;
                            if (eof_in) begin
                                state_q     <= DONE;
                                ready_q     <= 1'b0;
                                crc_valid_q <= 1'b1;
                                crc_out_q   <= crc_d ^ CRC_XOROUT;
                                isize_q     <= cnt_d;
                            end else begin
                                state_q <= ACCUM;
                            end
                        end
                    end
                end
                DONE: begin
`ifdef CRC_TRAILER_SER_EN
                    state_q     <= TRAILER;
                    trl_valid_q <= 1'b1;
                    trl_data_q  <= crc_out_q[7:0];
                    trl_idx_q   <= '0;
                    trl_last_q  <= 1'b0;
`else
                    state_q <= IDLE;
                    ready_q <= 1'b1;
`endif
                end
                TRAILER: begin
`ifdef CRC_TRAILER_SER_EN
                    if (trl_valid_q && trl_ready_in) begin
                        if (trl_idx_q == 3'd7) begin
                            state_q     <= IDLE;
                            ready_q     <= 1'b1;
                            trl_valid_q <= 1'b0;
                            trl_last_q  <= 1'b0;
                        end else begin
                            trl_idx_q  <= trl_idx_d;
                            trl_data_q <= trl_word[8*trl_idx_d +: 8];
                            trl_last_q <= (trl_idx_d == 3'd7);
                        end
                    end
`else
                    state_q <= IDLE;
                    ready_q <= 1'b1;
`endif
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out     = ready_q;
    assign crc_out       = crc_out_q;
    assign isize_out     = isize_q;
    assign crc_valid_out = crc_valid_q;
    assign err_out       = err_q;
`ifdef CRC_TRAILER_SER_EN
    assign trl_data_out  = trl_data_q;
    assign trl_valid_out = trl_valid_q;
    assign trl_last_out  = trl_last_q;
`endif

`ifndef SYNTHESIS
    // Debug check: enables of an accepted beat must be contiguous from bit 0.
    always @(posedge clk) begin
        if (!rst && data_valid_in && ready_q) begin
            assert ((data_be_in & (data_be_in + BE_ONE)) == '0);
        end
    end
`endif

endmodule
